// File: rtl/dl1_write_buffer.sv
// DL1 -> L2 write buffer: a circular FIFO of word writes. A write to the youngest
// entry's word is merged into that entry, and DL1 miss snoops see the youngest buffered data.
module dl1_write_buffer #(
    parameter int DATA_LENGTH = 32,
    parameter int BYTE_OFFSET = 2,
    parameter int WB_DEPTH    = 4
) (
    input  logic                                 clk_l2,
    input  logic                                 rst_n,
    input  logic                                 wb_req,
    input  logic [2*DATA_LENGTH-BYTE_OFFSET-1:0] wb_data,
    output logic                                 wb_ack,
    output logic                                 full_flag,
    output logic                                 wb_empty,
    input  logic                                 L2_full_flag,
    output logic                                 l2_wb_valid,
    output logic [DATA_LENGTH-BYTE_OFFSET-1:0]   l2_wb_addr,
    output logic [DATA_LENGTH-1:0]               l2_wb_data,
    input  logic                                 l2_wb_ready,
    input  logic [DATA_LENGTH-BYTE_OFFSET-1:0]   snoop_addr,
    output logic                                 snoop_hit,
    output logic [DATA_LENGTH-1:0]               snoop_data
);
    localparam int AW = DATA_LENGTH - BYTE_OFFSET;
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0]          addr_q [WB_DEPTH];
    logic [DATA_LENGTH-1:0] data_q [WB_DEPTH];
    logic [WB_DEPTH-1:0]    vld_q;
    logic [PW-1:0]          head, tail, young, sidx;
    logic [CW-1:0]          count;

    logic [AW-1:0]          in_addr;
    logic [DATA_LENGTH-1:0] in_data;
    logic                   accept, pop, young_pop, coalesce, allocate;

    assign in_addr = wb_data[AW+DATA_LENGTH-1:DATA_LENGTH];
    assign in_data = wb_data[DATA_LENGTH-1:0];
    assign young   = tail - PW'(1);

    assign wb_empty    = (count == '0);
    assign full_flag   = (count == CW'(WB_DEPTH));
    assign l2_wb_valid = !wb_empty && !L2_full_flag;
    assign l2_wb_addr  = addr_q[head];
    assign l2_wb_data  = data_q[head];

    assign accept    = wb_req && !wb_ack;
    assign pop       = l2_wb_valid && l2_wb_ready;
    // Merging into an entry that leaves this cycle would lose the write.
    assign young_pop = pop && (count == CW'(1));
    assign coalesce  = accept && vld_q[young] && (addr_q[young] == in_addr) && !young_pop;
    // A same-cycle pop never frees a slot for the incoming write.
    assign allocate  = accept && !coalesce && !full_flag;

    always_ff @(posedge clk_l2) begin
        if (!rst_n) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            vld_q  <= '0;
            wb_ack <= 1'b0;
        end else begin
            wb_ack <= coalesce || allocate;
            if (allocate) begin
                tail        <= tail + PW'(1);
                vld_q[tail] <= 1'b1;
            end
            if (pop) begin
                head        <= head + PW'(1);
                vld_q[head] <= 1'b0;
            end
            case ({allocate, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; entry validity lives in vld_q.
    always_ff @(posedge clk_l2) begin
        if (allocate) begin
            addr_q[tail] <= in_addr;
            data_q[tail] <= in_data;
        end
        if (coalesce)
            data_q[young] <= in_data;
    end

    // Walk oldest to youngest so the youngest match is the last one kept.
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = '0;
        sidx       = head;
        for (int k = 0; k < WB_DEPTH; k++) begin
            sidx = head + PW'(k);
            if (vld_q[sidx] && (addr_q[sidx] == snoop_addr)) begin
                snoop_hit  = 1'b1;
                snoop_data = data_q[sidx];
            end
        end
    end
endmodule

// File: tb/tb_dl1_write_buffer.sv
// Directed bench for dl1_write_buffer: a per-cycle vector table plus
// hand-written coalesce, snoop and stall/reset sequences.
module tb_dl1_write_buffer;
    logic        clk_l2 = 1'b0;
    logic        rst_n;
    logic        wb_req;
    logic [61:0] wb_data;
    logic        wb_ack, full_flag, wb_empty;
    logic        L2_full_flag;
    logic        l2_wb_valid;
    logic [29:0] l2_wb_addr;
    logic [31:0] l2_wb_data;
    logic        l2_wb_ready;
    logic [29:0] snoop_addr;
    logic        snoop_hit;
    logic [31:0] snoop_data;

    int tests = 0;
    int fails = 0;
    int pops  = 0;

    dl1_write_buffer #(.DATA_LENGTH(32), .BYTE_OFFSET(2), .WB_DEPTH(4)) dut (
        .clk_l2(clk_l2), .rst_n(rst_n), .wb_req(wb_req), .wb_data(wb_data),
        .wb_ack(wb_ack), .full_flag(full_flag), .wb_empty(wb_empty),
        .L2_full_flag(L2_full_flag), .l2_wb_valid(l2_wb_valid),
        .l2_wb_addr(l2_wb_addr), .l2_wb_data(l2_wb_data), .l2_wb_ready(l2_wb_ready),
        .snoop_addr(snoop_addr), .snoop_hit(snoop_hit), .snoop_data(snoop_data)
    );

    always #5 clk_l2 = ~clk_l2;

    always @(negedge clk_l2)
        if (l2_wb_valid && l2_wb_ready) pops++;

    typedef struct {
        logic        req;
        logic [29:0] a;
        logic [31:0] d;
        logic        rdy;
        logic [29:0] sa;
        logic        ack, full, empty, valid;
        logic [29:0] ea;
        logic [31:0] ed;
        logic        hit;
        logic [31:0] sd;
    } vec_t;

    vec_t tv[21];

    function automatic vec_t v(input logic req, input logic [29:0] a, input logic [31:0] d,
                               input logic rdy, input logic [29:0] sa, input logic ack,
                               input logic full, input logic empty, input logic valid,
                               input logic [29:0] ea, input logic [31:0] ed,
                               input logic hit, input logic [31:0] sd);
        vec_t r;
        r.req = req; r.a = a; r.d = d; r.rdy = rdy; r.sa = sa;
        r.ack = ack; r.full = full; r.empty = empty; r.valid = valid;
        r.ea = ea; r.ed = ed; r.hit = hit; r.sd = sd;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_l2);
        #1;
    endtask

    // Present one write, expect the ack the following cycle, then release wb_req.
    task automatic push(input string name, input logic [29:0] a, input logic [31:0] d);
        wb_req  = 1'b1;
        wb_data = {a, d};
        tick();
        chk({name, ".ack"}, 64'(wb_ack), 64'd1);
        wb_req = 1'b0;
        tick();
    endtask

    initial begin
        tv[0]  = v(1, 'h10, 'h567, 0, 'h10, 0, 0, 1, 0, 0,   0,     0, 0);
        tv[1]  = v(1, 'h10, 'h567, 0, 'h10, 1, 0, 0, 1, 'h10, 'h567, 1, 'h567);
        tv[2]  = v(0, 'h10, 'h567, 1, 'h10, 0, 0, 0, 1, 'h10, 'h567, 1, 'h567);
        tv[3]  = v(0, 0,    0,     0, 'h10, 0, 0, 1, 0, 0,   0,     0, 0);
        tv[4]  = v(1, 1, 'h101, 0, 0, 0, 0, 1, 0, 0, 0,     0, 0);
        tv[5]  = v(1, 1, 'h101, 0, 0, 1, 0, 0, 1, 1, 'h101, 0, 0);
        tv[6]  = v(1, 2, 'h102, 0, 0, 0, 0, 0, 1, 1, 'h101, 0, 0);
        tv[7]  = v(1, 2, 'h102, 0, 0, 1, 0, 0, 1, 1, 'h101, 0, 0);
        tv[8]  = v(1, 3, 'h103, 0, 0, 0, 0, 0, 1, 1, 'h101, 0, 0);
        tv[9]  = v(1, 3, 'h103, 0, 0, 1, 0, 0, 1, 1, 'h101, 0, 0);
        tv[10] = v(1, 4, 'h104, 0, 0, 0, 0, 0, 1, 1, 'h101, 0, 0);
        tv[11] = v(1, 4, 'h104, 0, 3, 1, 1, 0, 1, 1, 'h101, 1, 'h103);
        tv[12] = v(1, 5, 'h105, 0, 0, 0, 1, 0, 1, 1, 'h101, 0, 0);
        tv[13] = v(1, 5, 'h105, 1, 0, 0, 1, 0, 1, 1, 'h101, 0, 0);
        tv[14] = v(1, 5, 'h105, 0, 0, 0, 0, 0, 1, 2, 'h102, 0, 0);
        tv[15] = v(1, 5, 'h105, 0, 0, 1, 1, 0, 1, 2, 'h102, 0, 0);
        tv[16] = v(0, 0, 0,     1, 0, 0, 1, 0, 1, 2, 'h102, 0, 0);
        tv[17] = v(0, 0, 0,     1, 0, 0, 0, 0, 1, 3, 'h103, 0, 0);
        tv[18] = v(0, 0, 0,     1, 0, 0, 0, 0, 1, 4, 'h104, 0, 0);
        tv[19] = v(0, 0, 0,     1, 0, 0, 0, 0, 1, 5, 'h105, 0, 0);
        tv[20] = v(0, 0, 0,     0, 0, 0, 0, 1, 0, 0, 0,     0, 0);

        // Reset held two cycles with a pending request.
        rst_n = 1'b0; wb_req = 1'b1; wb_data = {30'h10, 32'h567};
        L2_full_flag = 1'b0; l2_wb_ready = 1'b0; snoop_addr = 30'h10;
        tick();
        tick();
        chk("rst.ack",   64'(wb_ack),      64'd0);
        chk("rst.full",  64'(full_flag),   64'd0);
        chk("rst.empty", 64'(wb_empty),    64'd1);
        chk("rst.valid", 64'(l2_wb_valid), 64'd0);
        chk("rst.hit",   64'(snoop_hit),   64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            wb_req = tv[i].req; wb_data = {tv[i].a, tv[i].d};
            l2_wb_ready = tv[i].rdy; snoop_addr = tv[i].sa;
            #1;
            chk($sformatf("v%0d.ack", i),   64'(wb_ack),      64'(tv[i].ack));
            chk($sformatf("v%0d.full", i),  64'(full_flag),   64'(tv[i].full));
            chk($sformatf("v%0d.empty", i), 64'(wb_empty),    64'(tv[i].empty));
            chk($sformatf("v%0d.valid", i), 64'(l2_wb_valid), 64'(tv[i].valid));
            chk($sformatf("v%0d.hit", i),   64'(snoop_hit),   64'(tv[i].hit));
            chk($sformatf("v%0d.sdata", i), 64'(snoop_data),  64'(tv[i].sd));
            if (tv[i].valid) begin
                chk($sformatf("v%0d.addr", i), 64'(l2_wb_addr), 64'(tv[i].ea));
                chk($sformatf("v%0d.data", i), 64'(l2_wb_data), 64'(tv[i].ed));
            end
            @(posedge clk_l2);
            #1;
        end

        // Coalesce into the single (youngest == head) entry.
        l2_wb_ready = 1'b0; snoop_addr = 30'h0;
        push("co1", 30'h20, 32'hAA);
        push("co2", 30'h20, 32'hBB);
        chk("co.valid", 64'(l2_wb_valid), 64'd1);
        chk("co.data",  64'(l2_wb_data),  64'hBB);
        l2_wb_ready = 1'b1;
        tick();
        l2_wb_ready = 1'b0;
        chk("co.empty", 64'(wb_empty), 64'd1);

        // A match that is not the youngest entry allocates a new slot.
        push("nc1", 30'h21, 32'h1);
        push("nc2", 30'h20, 32'h2);
        l2_wb_ready = 1'b1;
        #1;
        chk("nc.addr0", 64'(l2_wb_addr), 64'h21);
        tick();
        chk("nc.addr1", 64'(l2_wb_addr), 64'h20);
        chk("nc.data1", 64'(l2_wb_data), 64'h2);
        tick();
        l2_wb_ready = 1'b0;
        chk("nc.empty", 64'(wb_empty), 64'd1);

        // Snoop picks the youngest of several matches.
        push("sn1", 30'h30, 32'h1);
        push("sn2", 30'h31, 32'h2);
        push("sn3", 30'h30, 32'h3);
        snoop_addr = 30'h30; #1;
        chk("sn30.hit",  64'(snoop_hit),  64'd1);
        chk("sn30.data", 64'(snoop_data), 64'h3);
        snoop_addr = 30'h31; #1;
        chk("sn31.data", 64'(snoop_data), 64'h2);
        snoop_addr = 30'h32; #1;
        chk("sn32.hit",  64'(snoop_hit),  64'd0);
        chk("sn32.data", 64'(snoop_data), 64'h0);
        l2_wb_ready = 1'b1;
        tick(); tick(); tick();
        l2_wb_ready = 1'b0;
        chk("sn.empty", 64'(wb_empty), 64'd1);

        // Stall with two entries, then reset mid-stall.
        push("st1", 30'h40, 32'h11);
        chk("st.offer", 64'(l2_wb_valid), 64'd1);
        L2_full_flag = 1'b1; #1;
        chk("st.drop", 64'(l2_wb_valid), 64'd0);
        l2_wb_ready = 1'b1;
        pops = 0;
        push("st2", 30'h41, 32'h22);
        tick();
        chk("st.valid", 64'(l2_wb_valid), 64'd0);
        chk("st.empty", 64'(wb_empty),    64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("sr.empty", 64'(wb_empty), 64'd1);
        L2_full_flag = 1'b0; #1;
        chk("sr.valid", 64'(l2_wb_valid), 64'd0);
        tick();
        chk("sr.pops", 64'(pops), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dl1_write_buffer.md
# dl1_write_buffer

Write buffer between the DL1 cache and the L2 cache in the RVS192 memory hierarchy. It absorbs DL1 write-through traffic (wb_req/wb_data), holds up to WB_DEPTH address/data entries in FIFO order, and drains them into L2 whenever L2 is not full. It coalesces a write to the same word as the youngest entry. It also answers DL1 miss snoops so L2 never supplies data older than a buffered write.

## Interface
Parameters:
- DATA_LENGTH, 32, data word width
- BYTE_OFFSET, 2, byte-offset bits dropped from word addresses
- WB_DEPTH, 4, number of entries; power of two, at least 2

Ports:
- clk_l2  in  1  L2-domain clock; all state updates on its rising edge
- rst_n  in  1  synchronous, active-low reset
- wb_req  in  1  DL1 write request; held high until wb_ack is seen
- wb_data  in  2*DATA_LENGTH-BYTE_OFFSET  {word address[DATA_LENGTH-BYTE_OFFSET-1:0], data[DATA_LENGTH-1:0]}
- wb_ack  out  1  one-cycle accept pulse to DL1
- full_flag  out  1  high when count == WB_DEPTH
- wb_empty  out  1  high when count == 0
- L2_full_flag  in  1  L2 cannot take writes; blocks draining
- l2_wb_valid  out  1  head entry offered to L2
- l2_wb_addr  out  DATA_LENGTH-BYTE_OFFSET  head word address
- l2_wb_data  out  DATA_LENGTH  head data
- l2_wb_ready  in  1  L2 takes the head entry this cycle
- snoop_addr  in  DATA_LENGTH-BYTE_OFFSET  DL1 miss word address
- snoop_hit  out  1  a buffered entry matches snoop_addr
- snoop_data  out  DATA_LENGTH  data of the youngest matching entry

## Operation
- Storage is a circular array with a head pointer, a tail pointer and a count. The pointers are $clog2(WB_DEPTH) bits and wrap modulo WB_DEPTH. The count is $clog2(WB_DEPTH)+1 bits.
- Reset (rst_n=0 at an edge): head=tail=count=0 and all entry valid bits clear. wb_ack=0, full_flag=0, wb_empty=1, l2_wb_valid=0, snoop_hit=0. In-flight requests are dropped and DL1 must re-present them.
- Accept condition: wb_req && !wb_ack. This allows at most one accept every two cycles.
- **Coalesce:** the incoming address equals the youngest entry (tail-1) and that entry is not being popped this cycle. The youngest entry is being popped when count==1 and a pop occurs. On coalesce, overwrite that entry's data; count is unchanged. Coalesce is allowed while full.
- **Allocate:** no coalesce and count < WB_DEPTH. Write the entry at tail, then tail+1 and count+1.
- **Full, no coalesce:** not accepted; wb_ack stays 0 and DL1 keeps wb_req high. A pop in the same cycle does not free a slot for that cycle.
- Drain: l2_wb_valid = !wb_empty && !L2_full_flag. l2_wb_addr and l2_wb_data come combinationally from the head entry. Pop when l2_wb_valid && l2_wb_ready: head+1, count-1.
- Simultaneous allocate and pop: count is unchanged and both pointers advance.
- Snoop (combinational): compare snoop_addr against all valid entries. On multiple matches, the youngest entry (closest to tail) wins. snoop_data=0 when snoop_hit=0.

## Timing
- wb_ack is registered. It is high in the cycle after the accepting edge, for exactly one cycle.
- Entry write latency is one edge. A written entry is visible to snoop and drain in the cycle after acceptance.
- full_flag and wb_empty are decoded from the registered count, so they update the cycle after the push or pop that changes it.
- The head entry is stable while l2_wb_valid=1 and l2_wb_ready=0. Coalescing into the head is allowed only when count>1 is false and no pop occurs; the data change is then visible on l2_wb_data the next cycle.
- L2_full_flag rising mid-offer deasserts l2_wb_valid combinationally. No pop occurs in that cycle.
- Minimum latency from wb_req to l2_wb_valid on an empty buffer is one cycle.

## Test plan
- **Reset:** hold rst_n=0 for 2 cycles with wb_req=1 -> all outputs at their reset values and no wb_ack.
- **Single write:** push addr 0x10, data 0x567 -> wb_ack pulses the next cycle. l2_wb_valid=1 with addr 0x10, data 0x567. With l2_wb_ready=1 the entry drains and wb_empty=1.
- **Fill:** with l2_wb_ready=0, push addresses 0x1, 0x2, 0x3, 0x4 -> full_flag=1. A fifth push (0x5) gets no ack. Raise l2_wb_ready for one cycle -> 0x1 drains, 0x5 is acked on the following accept, and draining yields order 2, 3, 4, 5.
- **Coalesce:** push 0x20/0xAA, then 0x20/0xBB -> count stays 1 and L2 receives only 0xBB. Push 0x21 then 0x20 -> two entries allocated, with no coalesce behind a non-youngest match.
- **Snoop:** entries 0x30/0x1, 0x31/0x2, 0x30/0x3 -> snoop 0x30 gives hit=1, data=0x3. Snoop 0x32 gives hit=0, data=0.
- **Stall and reset:** L2_full_flag=1 with 2 entries -> l2_wb_valid=0 and no pops. Assert rst_n=0 mid-stall -> buffer empty the next cycle and no pop reaches L2.
